// File: rtl/fetch_pc_unit.sv
// Fetch PC sequencer and IF/ID register for a two-cycle (address, then data) instruction memory.
// Handles stall, memory-conflict refetch and branch/jump redirect with flush.
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] NOP_INSTRUCT = 16'b0000100000000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] pc,
  output logic        fetch_phase,
  input  logic [15:0] instruct_in,
  input  logic        mem_conflict,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic [15:0] id_instruct,
  output logic [15:0] id_pc_plus1,
  output logic        id_valid
);

  typedef enum logic {ADDR = 1'b0, DATA = 1'b1} phase_t;

  typedef struct packed {
    logic [15:0] instruct;
    logic [15:0] pc_plus1;
    logic        valid;
  } ifid_t;

  phase_t      phase_q, phase_d;
  logic [15:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic        pend_q, pend_d;
  logic [15:0] tgt_q, tgt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= ADDR;
      pc_q    <= RESET_PC;
      ifid_q  <= '{instruct: NOP_INSTRUCT, pc_plus1: 16'h0000, valid: 1'b0};
      pend_q  <= 1'b0;
      tgt_q   <= 16'h0000;
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    case (phase_q)
      ADDR: begin
        phase_d = DATA;
        // A redirect seen during the address phase is parked until the data edge.
        if (redirect_valid) begin
          pend_d = 1'b1;
          tgt_d  = redirect_target;
        end
      end
      DATA: begin
        phase_d = ADDR;
        if (redirect_valid || pend_q) begin
          pc_d           = redirect_valid ? redirect_target : tgt_q;
          ifid_d.instruct = NOP_INSTRUCT;
          ifid_d.valid    = 1'b0;
          pend_d         = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (mem_conflict) begin
          // instruct_in is not our word this time; bubble and refetch the same pc.
          ifid_d.instruct = NOP_INSTRUCT;
          ifid_d.valid    = 1'b0;
        end else begin
          ifid_d.instruct = instruct_in;
          ifid_d.pc_plus1 = pc_q + 16'd1;
          ifid_d.valid    = 1'b1;
          pc_d            = pc_q + 16'd1;
        end
      end
      default: phase_d = ADDR;
    endcase
  end

  assign pc          = pc_q;
  assign fetch_phase = (phase_q == DATA);
  assign id_instruct = ifid_q.instruct;
  assign id_pc_plus1 = ifid_q.pc_plus1;
  assign id_valid    = ifid_q.valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: rule-level model checked every cycle plus literal checkpoints.
module tb_fetch_pc_unit;
  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        fetch_phase;
  logic [15:0] instruct_in;
  logic        mem_conflict;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] id_instruct;
  logic [15:0] id_pc_plus1;
  logic        id_valid;

  fetch_pc_unit #(.RESET_PC(16'h0000), .NOP_INSTRUCT(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_phase(fetch_phase),
    .instruct_in(instruct_in), .mem_conflict(mem_conflict), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_instruct(id_instruct), .id_pc_plus1(id_pc_plus1), .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // model state
  logic        m_data;
  logic [15:0] m_pc, m_ins, m_pp1, m_tgt;
  logic        m_vld, m_pend;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = 1'b0; m_pc = 16'h0000; m_ins = NOP; m_pp1 = 16'h0000;
    m_vld = 1'b0; m_pend = 1'b0; m_tgt = 16'h0000;
  endtask

  // One clock: present inputs, take the edge, advance the model by the fetch rules.
  task automatic cyc(input logic rv, input logic [15:0] rt, input logic st, input logic mc);
    redirect_valid = rv; redirect_target = rt; stall = st; mem_conflict = mc;
    instruct_in = {8'h00, m_pc[7:0]};
    @(posedge clk);
    if (!m_data) begin
      if (rv) begin m_pend = 1'b1; m_tgt = rt; end
    end else if (rv || m_pend) begin
      m_pc = rv ? rt : m_tgt; m_ins = NOP; m_vld = 1'b0; m_pend = 1'b0;
    end else if (!st) begin
      if (mc) begin m_ins = NOP; m_vld = 1'b0; end
      else begin
        m_ins = instruct_in; m_pp1 = m_pc + 16'd1; m_vld = 1'b1; m_pc = m_pc + 16'd1;
      end
    end
    m_data = ~m_data;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic lit(input string tag, input logic [15:0] e_pc, input logic [15:0] e_ins,
                     input logic [15:0] e_pp1, input logic e_vld);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".ins"}, id_instruct, e_ins);
    chk({tag, ".pp1"}, id_pc_plus1, e_pp1);
    chk({tag, ".vld"}, {15'd0, id_valid}, {15'd0, e_vld});
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc.pc", pc, m_pc);
      chk("cyc.phase", {15'd0, fetch_phase}, {15'd0, m_data});
      chk("cyc.ins", id_instruct, m_ins);
      chk("cyc.pp1", id_pc_plus1, m_pp1);
      chk("cyc.vld", {15'd0, id_valid}, {15'd0, m_vld});
    end
  end

  initial begin
    rst = 1'b1; instruct_in = '0; mem_conflict = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    model_reset();
    #12;
    lit("reset", 16'h0000, NOP, 16'h0000, 1'b0);
    chk("reset.phase", {15'd0, fetch_phase}, 16'd0);
    @(negedge clk); rst = 1'b0; chk_en = 1'b1;

    // streaming fetch
    run(2);
    lit("first", 16'h0001, 16'h0000, 16'h0001, 1'b1);
    run(6);
    lit("stream8", 16'h0004, 16'h0003, 16'h0004, 1'b1);

    // stall across two data edges at pc=5
    run(2);
    lit("pre_stall", 16'h0005, 16'h0004, 16'h0005, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    lit("stalled", 16'h0005, 16'h0004, 16'h0005, 1'b1);
    run(2);
    lit("post_stall", 16'h0006, 16'h0005, 16'h0006, 1'b1);

    // mem_conflict at pc=3 (reach it via redirect to 2, then one normal fetch)
    cyc(1'b1, 16'h0002, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    lit("redir2", 16'h0002, NOP, 16'h0006, 1'b0);
    run(2);
    lit("pc3", 16'h0003, 16'h0002, 16'h0003, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    lit("conflict", 16'h0003, NOP, 16'h0003, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);   // conflict in address phase is ignored
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    lit("refetch", 16'h0004, 16'h0003, 16'h0004, 1'b1);

    // pending redirect overrides stall on the data edge
    cyc(1'b1, 16'h0040, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    lit("redir_stall", 16'h0040, NOP, 16'h0004, 1'b0);

    // live redirect beats pending; also overrides conflict
    cyc(1'b1, 16'h0100, 1'b0, 1'b0);
    cyc(1'b1, 16'h0200, 1'b0, 1'b1);
    lit("live_wins", 16'h0200, NOP, 16'h0004, 1'b0);

    // wrap FFFF -> 0000
    cyc(1'b1, 16'hFFFE, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    run(2);
    lit("fffe", 16'hFFFF, 16'h00FE, 16'hFFFF, 1'b1);
    run(2);
    lit("wrap", 16'h0000, 16'h00FF, 16'h0000, 1'b1);

    // async reset mid data phase with a redirect pending
    run(2);
    cyc(1'b1, 16'h1234, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    lit("async_rst", 16'h0000, NOP, 16'h0000, 1'b0);
    chk("async_rst.phase", {15'd0, fetch_phase}, 16'd0);
    @(negedge clk); rst = 1'b0;
    run(2);
    lit("drop_pend", 16'h0001, 16'h0000, 16'h0001, 1'b1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
